multicycle_controller: RTL

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 291 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Control FSM for a multicycle MIPS-like datapath. Each instruction walks through
// FETCH -> DECODE and then one of these paths:
//   ALU ops : EXEC -> WB
//   loads   : ADDR -> MEMRD -> LDWB
//   stores  : ADDR -> MEMWR
//   BEQ     : BRANCH
// Any instruction that cannot be decoded parks the FSM in TRAP until reset.
//
// Ports
//   clk            in   1   rising-edge clock
//   reset_n        in   1   asynchronous, active-low reset
//   opcode         in   6   IR[31:26]; held stable from DECODE to completion
//   funct          in   6   IR[5:0];   held stable from DECODE to completion
//   zero           in   1   ALU equality flag
//   mem_ready      in   1   memory accepts/completes the current mem_req
//   pc_write       out  1   PC load strobe
//   ir_write       out  1   IR load strobe
//   reg_write      out  1   register-file write strobe
//   mem_req        out  1   memory request
//   mem_we         out  1   memory write enable
//   i_or_d         out  1   memory address select (0 = PC, 1 = ALUOut)
//   reg_dst        out  1   write register select (1 = rd, 0 = rt)
//   mem_to_reg     out  1   write-back data select (1 = MDR, 0 = ALUOut)
//   pc_src         out  1   PC source (0 = ALU result, 1 = branch target register)
//   alu_src_a      out  1   ALU A select (0 = PC, 1 = rs)
//   alu_src_b      out  2   ALU B select (rt / 4 / sext imm / sext imm<<2)
//   alu_sel        out  3   ALU operation
//   mem_read_mode  out  2   0 none, 1 word, 2 half signed, 3 half unsigned
//   state          out  4   current FSM state encoding
//   illegal        out  1   sticky trap flag
//   retired_count  out  32  retired-instruction count
//
// Configuration macro
//   MULTICYCLE_CONTROLLER_PERF_CNT_EN
//     defined   : retired_count is a wrapping 32-bit counter of retired
//                 instructions.
//     undefined : retired_count is tied to 0 and no counter register exists.
// -----------------------------------------------------------------------------
module multicycle_controller (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic        mem_req,
    output logic        mem_we,
    output logic        i_or_d,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        pc_src,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_sel,
    output logic [1:0]  mem_read_mode,
    output logic [3:0]  state,
    output logic        illegal,
    output logic [31:0] retired_count
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_WB     = 4'd3,
        S_ADDR   = 4'd4,
        S_MEMRD  = 4'd5,
        S_LDWB   = 4'd6,
        S_MEMWR  = 4'd7,
        S_BRANCH = 4'd8,
        S_TRAP   = 4'd9
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd4;
    localparam logic [2:0] ALU_OR  = 3'd5;

    // R-type funct decode: {legal, alu_sel}.
    function automatic logic [3:0] rtype_decode(input logic [5:0] f);
        case (f)
            6'b100000: rtype_decode = {1'b1, 3'd0};  // add
            6'b100010: rtype_decode = {1'b1, 3'd1};  // sub
            6'b000000: rtype_decode = {1'b1, 3'd2};  // sll
            6'b000010: rtype_decode = {1'b1, 3'd3};  // srl
            6'b100100: rtype_decode = {1'b1, 3'd4};  // and
            6'b100101: rtype_decode = {1'b1, 3'd5};  // or
            6'b101010: rtype_decode = {1'b1, 3'd6};  // slt
            6'b101011: rtype_decode = {1'b1, 3'd7};  // sltu
            default:   rtype_decode = {1'b0, 3'd0};
        endcase
    endfunction

    state_t state_q, state_d;

    logic       rtype_legal;
    logic [2:0] rtype_sel;

    // Un-gated decode of the current state; reset gating is applied below.
    logic       pc_write_c, ir_write_c, reg_write_c, mem_req_c, mem_we_c;
    logic       i_or_d_c, reg_dst_c, mem_to_reg_c, pc_src_c, alu_src_a_c;
    logic [1:0] alu_src_b_c, mem_read_mode_c;
    logic [2:0] alu_sel_c;

    assign {rtype_legal, rtype_sel} = rtype_decode(funct);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        pc_write_c      = 1'b0;
        ir_write_c      = 1'b0;
        reg_write_c     = 1'b0;
        mem_req_c       = 1'b0;
        mem_we_c        = 1'b0;
        i_or_d_c        = 1'b0;
        reg_dst_c       = 1'b0;
        mem_to_reg_c    = 1'b0;
        pc_src_c        = 1'b0;
        alu_src_a_c     = 1'b0;
        alu_src_b_c     = 2'd0;
        alu_sel_c       = ALU_ADD;
        mem_read_mode_c = 2'd0;

        case (state_q)
            S_FETCH: begin
                // PC + 4 is computed while the instruction word is fetched.
                mem_req_c       = 1'b1;
                mem_read_mode_c = 2'd1;
                alu_src_b_c     = 2'd1;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_DECODE;
                end
            end

            S_DECODE: begin
                // Speculatively compute the branch target PC + (imm << 2).
                alu_src_b_c = 2'd3;
                case (opcode)
                    OP_RTYPE:                state_d = rtype_legal ? S_EXEC : S_TRAP;
                    OP_ADDI, OP_ANDI, OP_ORI: state_d = S_EXEC;
                    OP_LW, OP_LH, OP_LHU, OP_SW: state_d = S_ADDR;
                    OP_BEQ:                  state_d = S_BRANCH;
                    default:                 state_d = S_TRAP;
                endcase
            end

            S_EXEC: begin
                alu_src_a_c = 1'b1;
                if (opcode == OP_RTYPE) begin
                    alu_src_b_c = 2'd0;
                    alu_sel_c   = rtype_sel;
                end else begin
                    alu_src_b_c = 2'd2;
                    if (opcode == OP_ANDI) begin
                        alu_sel_c = ALU_AND;
                    end else if (opcode == OP_ORI) begin
                        alu_sel_c = ALU_OR;
                    end else begin
                        alu_sel_c = ALU_ADD;
                    end
                end
                state_d = S_WB;
            end

            S_WB: begin
                reg_write_c = 1'b1;
                reg_dst_c   = (opcode == OP_RTYPE);
                state_d     = S_FETCH;
            end

            S_ADDR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'd2;
                state_d     = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end

            S_MEMRD: begin
                mem_req_c = 1'b1;
                i_or_d_c  = 1'b1;
                case (opcode)
                    OP_LH:   mem_read_mode_c = 2'd2;
                    OP_LHU:  mem_read_mode_c = 2'd3;
                    default: mem_read_mode_c = 2'd1;
                endcase
                if (mem_ready) begin
                    state_d = S_LDWB;
                end
            end

            S_LDWB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = 1'b1;
                state_d      = S_FETCH;
            end

            S_MEMWR: begin
                mem_req_c = 1'b1;
                mem_we_c  = 1'b1;
                i_or_d_c  = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end
            end

            S_BRANCH: begin
                // rs - rt sets zero; the target latched in DECODE is taken on equality.
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'd0;
                alu_sel_c   = ALU_SUB;
                pc_src_c    = 1'b1;
                pc_write_c  = zero;
                state_d     = S_FETCH;
            end

            S_TRAP: begin
                state_d = S_TRAP;
            end

            // Unused encodings are treated as a fault.
            default: begin
                state_d = S_TRAP;
            end
        endcase
    end

    // Outputs are forced low combinationally while reset is held so that a
    // pending memory request is withdrawn in the same cycle reset asserts.
    assign pc_write      = pc_write_c   & reset_n;
    assign ir_write      = ir_write_c   & reset_n;
    assign reg_write     = reg_write_c  & reset_n;
    assign mem_req       = mem_req_c    & reset_n;
    assign mem_we        = mem_we_c     & reset_n;
    assign i_or_d        = i_or_d_c     & reset_n;
    assign reg_dst       = reg_dst_c    & reset_n;
    assign mem_to_reg    = mem_to_reg_c & reset_n;
    assign pc_src        = pc_src_c     & reset_n;
    assign alu_src_a     = alu_src_a_c  & reset_n;
    assign alu_src_b     = alu_src_b_c     & {2{reset_n}};
    assign alu_sel       = alu_sel_c       & {3{reset_n}};
    assign mem_read_mode = mem_read_mode_c & {2{reset_n}};
    assign state         = state_q;
    assign illegal       = (state_q == S_TRAP) & reset_n;

`ifdef MULTICYCLE_CONTROLLER_PERF_CNT_EN
    logic [31:0] retired_q;
    logic        retire;

    // An instruction retires when the FSM leaves one of its terminal states.
    assign retire = (state_d == S_FETCH) &&
                    ((state_q == S_WB)    || (state_q == S_LDWB) ||
                     (state_q == S_MEMWR) || (state_q == S_BRANCH));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retired_q <= 32'd0;
        end else if (retire) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    assign retired_count = retired_q;
`else
    assign retired_count = 32'd0;
`endif

endmodule
